// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave RAM with byte strobes, configurable read latency, SLVERR on
// out-of-range accesses and a saturating error counter.
module axi_lite_ram #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           DEPTH        = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    areset,
    // write address / data / response
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    // read address / data
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i,
    output logic [15:0]             err_count
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rstate_e;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // write channel state
    wstate_e               wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // read channel state
    rstate_e               rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [15:0]           err_count_q, err_count_d;

    // combinational helpers
    logic                  aw_hs_c, w_hs_c, ar_hs_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c, wr_off_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [STRB_W-1:0]     wr_strb_c;
    logic                  wr_in_range_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c, rd_off_c;
    logic                  rd_in_range_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  b_err_hs_c, r_err_hs_c;
    logic [16:0]           err_sum_c;

    assign aw_hs_c = s_axi_awvalid_i & awready_q;
    assign w_hs_c  = s_axi_wvalid_i & wready_q;
    assign ar_hs_c = s_axi_arvalid_i & arready_q;

    // Commit uses the held value or the one being captured on this edge.
    assign wr_addr_c     = aw_held_q ? aw_addr_q : s_axi_awaddr_i;
    assign wr_data_c     = w_held_q ? w_data_q : s_axi_wdata_i;
    assign wr_strb_c     = w_held_q ? w_strb_q : s_axi_wstrb_i;
    // BASE_ADDR is span-aligned, so addresses below it wrap to offsets >= SPAN.
    assign wr_off_c      = wr_addr_c - BASE_ADDR;
    assign wr_in_range_c = {1'b0, wr_off_c} < SPAN;
    assign wr_idx_c      = wr_off_c[LSB +: IDX_W];

    assign rd_addr_c     = (rstate_q == R_IDLE) ? s_axi_araddr_i : ar_addr_q;
    assign rd_off_c      = rd_addr_c - BASE_ADDR;
    assign rd_in_range_c = {1'b0, rd_off_c} < SPAN;
    assign rd_idx_c      = rd_off_c[LSB +: IDX_W];
    assign rd_word_c     = rd_in_range_c ? mem[rd_idx_c] : '0;

    // Write FSM next-state and outputs.
    always_comb begin
        wstate_d   = wstate_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_we_c   = 1'b0;
        b_err_hs_c = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_axi_awaddr_i;
                end
                if (w_hs_c) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axi_wdata_i;
                    w_strb_d = s_axi_wstrb_i;
                end
                if ((aw_held_q || aw_hs_c) && (w_held_q || w_hs_c)) begin
                    wstate_d  = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    mem_we_c  = wr_in_range_c;
                end else begin
                    awready_d = !(aw_held_q || aw_hs_c);
                    wready_d  = !(w_held_q || w_hs_c);
                end
            end
            W_RESP: begin
                if (s_axi_bready_i) begin
                    wstate_d   = W_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    bvalid_d   = 1'b0;
                    b_err_hs_c = (bresp_q == RESP_SLVERR);
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read FSM next-state and outputs; RAM is sampled on the edge entering DATA.
    always_comb begin
        rstate_d   = rstate_q;
        ar_addr_d  = ar_addr_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        r_err_hs_c = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    ar_addr_d = s_axi_araddr_i;
                    arready_d = 1'b0;
                    if (READ_LATENCY == 1) begin
                        rstate_d = R_DATA;
                        rvalid_d = 1'b1;
                        rdata_d  = rd_word_c;
                        rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rstate_d = R_DATA;
                rvalid_d = 1'b1;
                rdata_d  = rd_word_c;
                rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
            end
            R_DATA: begin
                if (s_axi_rready_i) begin
                    rstate_d   = R_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                    r_err_hs_c = (rresp_q == RESP_SLVERR);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Saturating error counter; B and R errors in one cycle add two.
    always_comb begin
        err_sum_c   = {1'b0, err_count_q} + 17'(b_err_hs_c) + 17'(r_err_hs_c);
        err_count_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wstate_q    <= W_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rstate_q    <= R_IDLE;
            ar_addr_q   <= '0;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            err_count_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rstate_q    <= rstate_d;
            ar_addr_q   <= ar_addr_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage is not reset; a reset edge suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (!areset && mem_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb_c[b]) begin
                    mem[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready_o = awready_q;
    assign s_axi_wready_o  = wready_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_arready_o = arready_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rdata_o   = rdata_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Bench for axi_lite_ram: directed scenarios plus random traffic against a word-array model.
module tb_axi_lite_ram;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned SPAN  = DEPTH * 4;

    logic          clk = 1'b0;
    logic          areset;
    logic [31:0]   awaddr, wdata, araddr;
    logic [3:0]    wstrb;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [15:0]   err_count;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;

    logic [31:0]   ref_mem [DEPTH];
    int unsigned   ref_err = 0;

    axi_lite_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .areset(areset),
        .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
        .s_axi_wready_o(wready), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
        .s_axi_bready_i(bready), .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid),
        .s_axi_arready_o(arready), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
        .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-addressed window of DEPTH words starting at BASE.
    function automatic bit m_in_range(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(SPAN));
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_in_range(a) ? ref_mem[m_idx(a)] : 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic m_count_err(input logic [1:0] r);
        if (r == 2'b10 && ref_err < 32'hFFFF) ref_err++;
    endtask

    // mode 0: AW and W together; 1: AW two cycles before W; 2: W two cycles before AW.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            awvalid = !aw_done && (mode != 2 || cyc >= 2);
            wvalid  = !w_done && (mode != 1 || cyc >= 2);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            cyc++;
            if (aw_done && !w_done) check_eq("awready_low_after_aw", 64'(awready), 64'(0));
            if (w_done && !aw_done) check_eq("wready_low_after_w", 64'(wready), 64'(0));
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("write_handshakes", 64'({aw_done, w_done}), 64'(2'b11));
        m_write(a, d, s);
        check_eq("bvalid_after_capture", 64'(bvalid), 64'(1));
        check_eq("bresp", 64'(bresp), 64'(m_resp(a)));
        check_eq("aw_w_ready_in_resp", 64'({awready, wready}), 64'(2'b00));
        tick();
        m_count_err(m_resp(a));
        check_eq("bvalid_after_b", 64'(bvalid), 64'(0));
        check_eq("aw_w_ready_after_b", 64'({awready, wready}), 64'(2'b11));
        check_eq("err_count_w", 64'(err_count), 64'(ref_err));
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] got);
        bit fired, fire_next;
        int cyc;
        logic [31:0] exp_d;
        exp_d = m_read(a);
        araddr = a; rready = 1'b1; arvalid = 1'b1;
        fired = 0; cyc = 0;
        while (!fired && cyc < 20) begin
            fire_next = arready;
            tick();
            fired = fire_next;
            cyc++;
        end
        arvalid = 1'b0;
        check_eq("ar_handshake", 64'(fired), 64'(1));
        check_eq("arready_low_after_ar", 64'(arready), 64'(0));
        for (int k = 1; k < int'(LAT); k++) begin
            check_eq("rvalid_early", 64'(rvalid), 64'(0));
            tick();
        end
        check_eq("rvalid_on_time", 64'(rvalid), 64'(1));
        check_eq("rdata", 64'(rdata), 64'(exp_d));
        check_eq("rresp", 64'(rresp), 64'(m_resp(a)));
        got = rdata;
        tick();
        m_count_err(m_resp(a));
        check_eq("rvalid_after_r", 64'(rvalid), 64'(0));
        check_eq("arready_after_r", 64'(arready), 64'(1));
        check_eq("err_count_r", 64'(err_count), 64'(ref_err));
    endtask

    initial begin
        logic [31:0] got, a, b, d;
        int sel;
        areset = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick(); tick();
        areset = 1'b0;

        check_eq("rst_readies", 64'({awready, wready, arready}), 64'(3'b111));
        check_eq("rst_valids", 64'({bvalid, rvalid}), 64'(2'b00));
        check_eq("rst_resps", 64'({bresp, rresp}), 64'(4'b0000));
        check_eq("rst_rdata", 64'(rdata), 64'(0));
        check_eq("rst_err", 64'(err_count), 64'(0));

        // Fill the whole RAM so the model starts fully defined.
        for (int i = 0; i < int'(DEPTH); i++) axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0);

        axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
        axi_read(BASE + 32'h10, got);
        check_eq("deadbeef_readback", 64'(got), 64'(32'hDEADBEEF));

        axi_write(BASE + 32'h20, 32'h0BADF00D, 4'hF, 2);
        axi_write(BASE + 32'h24, 32'hCAFEBABE, 4'hF, 1);
        axi_write(BASE + 32'h28, 32'hFFFFFFFF, 4'hF, 0);
        axi_write(BASE + 32'h28, 32'h11223344, 4'b0101, 0);
        axi_read(BASE + 32'h28, got);
        check_eq("strobe_merge", 64'(got), 64'(32'hFF22FF44));
        axi_write(BASE + 32'h2C, 32'h12345678, 4'h0, 0);
        axi_read(BASE + 32'h2C, got);

        // Out-of-range accesses just past the top and just below the window.
        axi_write(BASE + 32'(SPAN), 32'h55AA55AA, 4'hF, 0);
        axi_read(BASE + 32'(SPAN), got);
        axi_write(BASE - 32'd4, 32'h55AA55AA, 4'hF, 0);
        axi_read(BASE - 32'd4, got);
        check_eq("err_after_oob", 64'(err_count), 64'(4));
        axi_read(BASE + 32'(SPAN - 4), got);

        // Backpressure: hold B and R for five cycles.
        a = BASE + 32'h40; b = BASE + 32'h44;
        awaddr = a; wdata = 32'h0F0F1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = b; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        d = m_read(b);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        m_write(a, 32'h0F0F1234, 4'hF);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_valids", 64'({bvalid, rvalid}), 64'(2'b11));
            check_eq("hold_resps", 64'({bresp, rresp}), 64'(4'b0000));
            check_eq("hold_rdata", 64'(rdata), 64'(d));
            check_eq("hold_readies", 64'({awready, wready, arready}), 64'(3'b000));
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        check_eq("release_valids", 64'({bvalid, rvalid}), 64'(2'b00));
        check_eq("release_readies", 64'({awready, wready, arready}), 64'(3'b111));

        // Simultaneous SLVERR on B and R.
        awaddr = BASE + 32'(SPAN) + 32'h80; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = BASE - 32'h100; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick(); tick();
        check_eq("dual_rdata_zero", 64'(rdata), 64'(0));
        check_eq("dual_resps", 64'({bresp, rresp}), 64'(4'b1010));
        bready = 1'b1; rready = 1'b1;
        tick();
        m_count_err(2'b10); m_count_err(2'b10);
        check_eq("dual_err_count", 64'(err_count), 64'(ref_err));

        // Read-first collision: RAM read and write commit on the same edge.
        a = BASE + 32'h30;
        axi_write(a, 32'hA5A5A5A5, 4'hF, 0);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        awaddr = a; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("collision_rvalid", 64'(rvalid), 64'(1));
        check_eq("collision_old_data", 64'(rdata), 64'(32'hA5A5A5A5));
        check_eq("collision_bvalid", 64'(bvalid), 64'(1));
        m_write(a, 32'h5A5A5A5A, 4'hF);
        tick();
        axi_read(a, got);
        check_eq("collision_new_data", 64'(got), 64'(32'h5A5A5A5A));

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) a = BASE + 32'(SPAN) + 32'($urandom_range(0, 63) * 4);
            else if (sel == 1) a = BASE - 32'($urandom_range(1, 16) * 4);
            else a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            else
                axi_read(a, got);
        end

        // Reset while B is pending and a read sits in WAIT.
        a = BASE + 32'h50;
        awaddr = a; wdata = 32'h600DCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        m_write(a, 32'h600DCAFE, 4'hF);
        check_eq("pre_rst_bvalid", 64'(bvalid), 64'(1));
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check_eq("pre_rst_wait", 64'({rvalid, arready}), 64'(2'b00));
        areset = 1'b1;
        tick();
        areset = 1'b0;
        ref_err = 0;
        bready = 1'b1;
        check_eq("mid_rst_valids", 64'({bvalid, rvalid}), 64'(2'b00));
        check_eq("mid_rst_readies", 64'({awready, wready, arready}), 64'(3'b111));
        check_eq("mid_rst_err", 64'(err_count), 64'(0));
        check_eq("mid_rst_rdata", 64'(rdata), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("no_stale_resp", 64'({bvalid, rvalid}), 64'(2'b00));
        end
        axi_read(a, got);
        check_eq("ram_kept_over_reset", 64'(got), 64'(32'h600DCAFE));
        axi_read(BASE + 32'h10, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
